// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared result-path definitions for the out-of-order core.
//                Holds the natural result data/tag widths, the result record
//                written by the ROB and register-bank writers, and a small
//                index-wrapping helper used by round-robin logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Natural widths of the result path.
    localparam int CORE_DATA_W = 16;
    localparam int CORE_TAG_W  = 4;

    // One result as seen by the register bank / ROB write side.
    typedef struct packed {
        logic [CORE_DATA_W-1:0] data;
        logic [CORE_TAG_W-1:0]  tag;
    } result_t;

    // Reduce idx into 0..n-1. The arguments stay below 2*n, so a single
    // conditional subtract is enough. Non-power-of-two n wraps explicitly.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority picker. Starting at index
//                ptr and moving upward (mod NUM_REQ), the first asserted
//                request bit wins.
//  Ports       : req        - request vector, one bit per unit
//                ptr        - highest-priority index this cycle (< NUM_REQ)
//                winner     - index of the winning request (0 when none)
//                any_valid  - at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import core_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   winner,
    output logic               any_valid
);

    // Walk offsets from farthest to nearest so that the last match written
    // is the one closest to ptr, i.e. the highest-priority requester.
    always_comb begin
        int w_idx;
        winner = '0;
        w_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = wrap_idx(int'(ptr) + k, NUM_REQ);
            if (req[w_idx]) begin
                winner = SRC_W'(w_idx);
            end
        end
    end

    assign any_valid = |req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : result_bus_arbiter
//  Description : Round-robin arbiter sharing one registered result bus among
//                NUM_REQ functional units. At most one valid/ready handshake
//                per cycle; the winner is captured into the bus register,
//                which holds while the consumer stalls.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous, active-high reset
//                req_valid  - per-unit result valid
//                req_data   - per-unit data, unit i at [i*DATA_W +: DATA_W]
//                req_tag    - per-unit tag,  unit i at [i*TAG_W +: TAG_W]
//                req_ready  - one-hot (or zero) accept strobe, combinational
//                bus_stall  - consumer cannot take the bus value this cycle
//                bus_valid  - bus holds a valid result
//                bus_data   - registered result data
//                bus_tag    - registered destination tag
//                bus_src    - index of the unit that produced the bus value
//  Revision    : 1.0 - initial release
// ============================================================================
module result_bus_arbiter
    import core_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = CORE_DATA_W,
    parameter int TAG_W   = CORE_TAG_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      bus_stall,
    output logic                      bus_valid,
    output logic [DATA_W-1:0]         bus_data,
    output logic [TAG_W-1:0]          bus_tag,
    output logic [SRC_W-1:0]          bus_src
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                r_bus_valid;
    logic [DATA_W-1:0]   r_bus_data;
    logic [TAG_W-1:0]    r_bus_tag;
    logic [SRC_W-1:0]    r_bus_src;
    logic [SRC_W-1:0]    r_rr_ptr;

    // ------------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------------
    logic                w_load;
    logic                w_any_valid;
    logic                w_accept;
    logic [SRC_W-1:0]    w_winner;
    logic [SRC_W-1:0]    w_next_ptr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [TAG_W-1:0]    w_sel_tag;

    // The bus register can take a new value when it is empty or the
    // consumer is taking the current one.
    assign w_load = ~r_bus_valid | ~bus_stall;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    // Reset blocks any handshake so a request is never acknowledged and
    // then discarded.
    assign w_accept = ~rst & w_load & w_any_valid;

    // Grant strobe is formed only from the pick result, never from any
    // requester's own ready, so there is no combinational loop through it.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept && (w_winner == SRC_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Winner data/tag mux, written as an explicit compare per unit to keep
    // index arithmetic out of the part-select.
    always_comb begin
        w_sel_data = '0;
        w_sel_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == SRC_W'(i)) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Pointer moves one past the winner; wraps explicitly for
    // non-power-of-two NUM_REQ so it never leaves 0..NUM_REQ-1.
    assign w_next_ptr = SRC_W'(wrap_idx(int'(w_winner) + 1, NUM_REQ));

    // ------------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_bus_tag   <= '0;
            r_bus_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_any_valid) begin
                r_bus_valid <= 1'b1;
                r_bus_data  <= w_sel_data;
                r_bus_tag   <= w_sel_tag;
                r_bus_src   <= w_winner;
                r_rr_ptr    <= w_next_ptr;
            end else begin
                // Bubble: data/tag/src keep their last value for debug
                // visibility; only the valid flag drops.
                r_bus_valid <= 1'b0;
            end
        end
    end

    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;
    assign bus_tag   = r_bus_tag;
    assign bus_src   = r_bus_src;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
    a_ptr_in_range  : assert property (@(posedge clk) disable iff (rst)
                                       (int'(r_rr_ptr) < NUM_REQ));
    a_src_in_range  : assert property (@(posedge clk) disable iff (rst)
                                       (int'(r_bus_src) < NUM_REQ));

endmodule : result_bus_arbiter
`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_bus_arbiter
//  Description : Directed self-checking bench for result_bus_arbiter with a
//                cycle-level reference model compared on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 4;
    localparam int SRC_W   = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bus_stall;
    logic                      bus_valid;
    logic [DATA_W-1:0]         bus_data;
    logic [TAG_W-1:0]          bus_tag;
    logic [SRC_W-1:0]          bus_src;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    result_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .SRC_W   (SRC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .bus_stall (bus_stall),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_tag   (bus_tag),
        .bus_src   (bus_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the bus is a one-entry register; the pointer names the
    // unit with highest priority. Everything is derived from the rules.
    // ------------------------------------------------------------------------
    logic             m_valid = 1'b0;
    logic [15:0]      m_data  = '0;
    logic [3:0]       m_tag   = '0;
    int               m_src   = 0;
    int               m_ptr   = 0;

    function automatic int model_winner(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always begin
        @(negedge clk);
        if (started) begin
            int  w;
            bit  can_take;
            logic [NUM_REQ-1:0] exp_ready;
            can_take  = !m_valid || !bus_stall;
            w         = model_winner(req_valid, m_ptr);
            exp_ready = '0;
            if (!rst && can_take && w >= 0) exp_ready[w] = 1'b1;

            chk("m_ready", 32'(req_ready), 32'(exp_ready));
            chk("m_valid", 32'(bus_valid), 32'(m_valid));
            chk("m_data",  32'(bus_data),  32'(m_data));
            chk("m_tag",   32'(bus_tag),   32'(m_tag));
            chk("m_src",   32'(bus_src),   32'(m_src));

            // Inputs stay stable until after the next rising edge.
            if (rst) begin
                m_valid = 1'b0; m_data = '0; m_tag = '0; m_src = 0; m_ptr = 0;
            end else if (can_take) begin
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_data  = req_data[w*DATA_W +: DATA_W];
                    m_tag   = req_tag[w*TAG_W +: TAG_W];
                    m_src   = w;
                    m_ptr   = (w + 1) % NUM_REQ;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [15:0] d, input logic [3:0] t);
        req_data[i*DATA_W +: DATA_W] = d;
        req_tag[i*TAG_W +: TAG_W]    = t;
    endtask

    task automatic default_units();
        for (int i = 0; i < NUM_REQ; i++) set_unit(i, 16'hA0A0 + 16'(i), 4'(8 + i));
    endtask

    task automatic chk_bus(input string name, input logic v, input logic [15:0] d,
                           input logic [3:0] t, input logic [1:0] s);
        chk({name, "_valid"}, 32'(bus_valid), 32'(v));
        chk({name, "_data"},  32'(bus_data),  32'(d));
        chk({name, "_tag"},   32'(bus_tag),   32'(t));
        chk({name, "_src"},   32'(bus_src),   32'(s));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        bus_stall = 1'b0;
        default_units();

        // 1. Reset for two cycles with everyone requesting.
        @(posedge clk);
        started = 1'b1;
        #1;
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);
        chk("rst_data",  32'(bus_data),  32'h0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);
        tick();
        chk_bus("first_bus", 1'b1, 16'hA0A0, 4'h8, 2'd0);

        // 2. Single requester unit 2 (pointer is now 1).
        req_valid = 4'b0100;
        set_unit(2, 16'hBEEF, 4'h5);
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        chk_bus("single_bus", 1'b1, 16'hBEEF, 4'h5, 2'd2);
        default_units();

        // Pointer is 3; one grant to unit 3 brings it back to 0.
        req_valid = 4'b1000;
        #1;
        chk("align_ready", 32'(req_ready), 32'b1000);
        tick();

        // 3. All units requesting: grants 0,1,2,3,0,1.
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_src",  32'(bus_src),  32'(k % 4));
            chk("rr_data", 32'(bus_data), 32'(16'hA0A0 + 16'(k % 4)));
        end

        // 4. Stall with bus holding unit 1; units 1 and 3 request.
        bus_stall = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            tick();
            chk_bus("stall_bus", 1'b1, 16'hA0A1, 4'h9, 2'd1);
        end
        bus_stall = 1'b0;
        #1;
        chk("resume_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_bus("resume_bus", 1'b1, 16'hA0A3, 4'hB, 2'd3);

        // 5. Gap after the grant to unit 3, then unit 0 after the wrap.
        req_valid = 4'b0000;
        #1;
        chk("gap_ready", 32'(req_ready), 32'h0);
        tick();
        chk_bus("gap_bus", 1'b0, 16'hA0A3, 4'hB, 2'd3);
        req_valid = 4'b0001;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_bus("wrap_bus", 1'b1, 16'hA0A0, 4'h8, 2'd0);

        // 6. Reset while stalled with a valid bus value.
        bus_stall = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk_bus("post_rst_bus", 1'b0, 16'h0000, 4'h0, 2'd0);
        rst = 1'b0;
        // Stall with an empty bus does not block loading; pointer is 0.
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        chk_bus("post_rst_grant", 1'b1, 16'hA0A0, 4'h8, 2'd0);

        bus_stall = 1'b0;
        req_valid = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_result_bus_arbiter
`default_nettype wire
